// File: rtl/turf_fragment_gen_mc.sv
// Event fragmenter: arbitrates NCHAN ctrl/data channel pairs and emits a UDP header,
// a tag beat and the payload beats of each fragment, flagging beat-count mismatches.
module turf_fragment_gen_mc #(
  parameter int          NCHAN    = 2,
  parameter logic [15:0] CONSTANT = 16'hDA7A
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic [9:0]           nfragment_count_i,
  input  logic [NCHAN*32-1:0]  s_ctrl_tdata,
  input  logic [NCHAN-1:0]     s_ctrl_tvalid,
  output logic [NCHAN-1:0]     s_ctrl_tready,
  input  logic [NCHAN*64-1:0]  s_data_tdata,
  input  logic [NCHAN*8-1:0]   s_data_tkeep,
  input  logic [NCHAN-1:0]     s_data_tlast,
  input  logic [NCHAN-1:0]     s_data_tvalid,
  output logic [NCHAN-1:0]     s_data_tready,
  output logic [15:0]          m_hdr_tdata,
  output logic [4:0]           m_hdr_tdest,
  output logic                 m_hdr_tvalid,
  input  logic                 m_hdr_tready,
  output logic [63:0]          m_payload_tdata,
  output logic [7:0]           m_payload_tkeep,
  output logic                 m_payload_tuser,
  output logic                 m_payload_tlast,
  output logic                 m_payload_tvalid,
  input  logic                 m_payload_tready,
  output logic                 err_o,
  output logic [15:0]          err_count_o
);

  typedef enum logic [1:0] {StIdle, StHeader, StTag, StStream} state_t;

  state_t      r_state;
  logic [4:0]  r_chan, r_last_grant;
  logic [11:0] r_addr;
  logic [19:0] r_len, r_rem, r_total;
  logic [9:0]  r_nfrag, r_frag_num, r_frag_beats;
  logic        r_last, r_err;
  logic [15:0] r_err_count;

  logic        w_grant_found;
  logic [4:0]  w_grant;
  logic [31:0] w_ctrl_word;
  logic [63:0] w_sel_tdata;
  logic [7:0]  w_sel_tkeep;
  logic        w_sel_tlast, w_sel_tvalid;
  logic [20:0] w_rem_sum, w_len_sum;
  logic [10:0] w_nfrag_p1;
  logic        w_fits, w_frag_last, w_beat;
  logic [19:0] w_payload;

  // Round robin: lowest valid channel above last_grant, else lowest valid overall.
  always_comb begin
    w_grant_found = 1'b0;
    w_grant       = '0;
    for (int j = NCHAN - 1; j >= 0; j--) begin
      if (s_ctrl_tvalid[j] && (5'(j) > r_last_grant)) begin
        w_grant_found = 1'b1;
        w_grant       = 5'(j);
      end
    end
    if (!w_grant_found) begin
      for (int j = NCHAN - 1; j >= 0; j--) begin
        if (s_ctrl_tvalid[j]) begin
          w_grant_found = 1'b1;
          w_grant       = 5'(j);
        end
      end
    end
  end

  always_comb begin
    w_ctrl_word   = '0;
    w_sel_tdata   = '0;
    w_sel_tkeep   = '0;
    w_sel_tlast   = 1'b0;
    w_sel_tvalid  = 1'b0;
    s_ctrl_tready = '0;
    s_data_tready = '0;
    for (int j = 0; j < NCHAN; j++) begin
      if (w_grant == 5'(j)) w_ctrl_word = s_ctrl_tdata[j*32 +: 32];
      if (r_chan == 5'(j)) begin
        w_sel_tdata  = s_data_tdata[j*64 +: 64];
        w_sel_tkeep  = s_data_tkeep[j*8 +: 8];
        w_sel_tlast  = s_data_tlast[j];
        w_sel_tvalid = s_data_tvalid[j];
      end
      s_ctrl_tready[j] = (r_state == StIdle) && w_grant_found && (w_grant == 5'(j));
      s_data_tready[j] = (r_state == StStream) && (r_chan == 5'(j)) && m_payload_tready;
    end
  end

  // Fragment sizing; an exhausted remaining count on a non-empty event yields an
  // empty, non-final fragment so overlong data keeps streaming.
  always_comb begin
    w_rem_sum   = {1'b0, r_rem} + 21'd7;
    w_len_sum   = {1'b0, r_len} + 21'd7;
    w_nfrag_p1  = {1'b0, r_nfrag} + 11'd1;
    w_fits      = {7'd0, w_nfrag_p1} >= w_rem_sum[20:3];
    w_frag_last = w_fits && !((r_rem == 20'd0) && (r_len != 20'd0));
    w_payload   = w_fits ? r_rem : {6'd0, w_nfrag_p1, 3'b000};
    w_beat      = (r_state == StStream) && w_sel_tvalid && m_payload_tready;
  end

  always_comb begin
    m_hdr_tvalid     = (r_state == StHeader);
    m_hdr_tdata      = w_payload[15:0] + 16'd8;
    m_hdr_tdest      = r_chan;
    m_payload_tuser  = 1'b0;
    m_payload_tvalid = 1'b0;
    m_payload_tdata  = '0;
    m_payload_tkeep  = '0;
    m_payload_tlast  = 1'b0;
    unique case (r_state)
      StTag: begin
        m_payload_tvalid = 1'b1;
        m_payload_tdata  = {CONSTANT, r_last, r_chan, r_frag_num, r_addr, r_len};
        m_payload_tkeep  = 8'hFF;
        m_payload_tlast  = (r_len == 20'd0);
      end
      StStream: begin
        m_payload_tvalid = w_sel_tvalid;
        m_payload_tdata  = w_sel_tdata;
        m_payload_tkeep  = w_sel_tkeep;
        m_payload_tlast  = w_sel_tlast;
      end
      default: ;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state      <= StIdle;
      r_chan       <= '0;
      r_last_grant <= 5'(NCHAN - 1);
      r_addr       <= '0;
      r_len        <= '0;
      r_rem        <= '0;
      r_total      <= '0;
      r_nfrag      <= '0;
      r_frag_num   <= '0;
      r_frag_beats <= '0;
      r_last       <= 1'b0;
      r_err        <= 1'b0;
      r_err_count  <= '0;
    end else begin
      r_err <= 1'b0;
      unique case (r_state)
        StIdle: if (w_grant_found) begin
          r_chan       <= w_grant;
          r_last_grant <= w_grant;
          r_addr       <= w_ctrl_word[31:20];
          r_len        <= w_ctrl_word[19:0];
          r_rem        <= w_ctrl_word[19:0];
          r_nfrag      <= nfragment_count_i;
          r_frag_num   <= '0;
          r_total      <= '0;
          r_state      <= StHeader;
        end
        StHeader: if (m_hdr_tready) begin
          r_last  <= w_frag_last;
          r_rem   <= r_rem - w_payload;
          r_state <= StTag;
        end
        StTag: if (m_payload_tready) begin
          r_frag_num   <= r_frag_num + 10'd1;
          r_frag_beats <= '0;
          r_state      <= (r_len == 20'd0) ? StIdle : StStream;
        end
        StStream: if (w_beat) begin
          r_total <= r_total + 20'd1;
          if (w_sel_tlast) begin
            r_state <= StIdle;
            if ((r_total + 20'd1) != {2'b00, w_len_sum[20:3]}) begin
              r_err <= 1'b1;
              if (r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
            end
          end else if (r_frag_beats == r_nfrag) begin
            r_state <= StHeader;
          end else begin
            r_frag_beats <= r_frag_beats + 10'd1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign err_o       = r_err;
  assign err_count_o = r_err_count;

endmodule
